// File: rtl/zero_flag_pipe_pkg.sv
// zero_flag_pipe_pkg
// Elaboration-time helpers for the pipelined zero/negative flag generator:
//   calc_levels    - number of OR-tree levels, ceil(log_fanin(width)), minimum 1
//   pow_int        - integer power
//   padded_width   - operand width rounded up to fanin**levels (pad bits are 0)
//   level_width    - number of nodes at tree level k (level 0 = padded operand)
//   level_offset   - bit offset of level k inside the flattened tree vector
package zero_flag_pipe_pkg;

  function automatic int calc_levels(input int width, input int fanin);
    int lv;
    int cap;
    lv  = 1;
    cap = fanin;
    while (cap < width) begin
      cap = cap * fanin;
      lv  = lv + 1;
    end
    return lv;
  endfunction

  function automatic int pow_int(input int base, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * base;
    return r;
  endfunction

  function automatic int padded_width(input int width, input int fanin);
    return pow_int(fanin, calc_levels(width, fanin));
  endfunction

  function automatic int level_width(input int width, input int fanin, input int k);
    return padded_width(width, fanin) / pow_int(fanin, k);
  endfunction

  // Levels are packed back to back, level 0 at bit 0.
  function automatic int level_offset(input int width, input int fanin, input int k);
    int off;
    off = 0;
    for (int i = 0; i < k; i++) off = off + level_width(width, fanin, i);
    return off;
  endfunction

endpackage

// File: rtl/zero_flag_level.sv
// zero_flag_level
// One registered FANIN-ary OR level of the zero-flag tree, with the valid bit,
// operand MSB and tag riding alongside. With ZERO_FLAG_PIPE_LZC_EN defined it
// also merges the per-node leading-zero counts of its children.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   stall, flush    - hold all registers / clear the valid bit (flush wins)
//   valid_i/valid_o - valid bit in from previous level, registered out
//   msb_i/msb_o     - operand MSB in, registered out
//   tag_i/tag_o     - tag in, registered out (loads only with a live operand)
//   or_i/or_o       - child OR bits (OUT_W*FANIN), registered group ORs (OUT_W)
//   lzc_i/lzc_o     - child / merged leading-zero counts, LZW bits per node
//                     (only with ZERO_FLAG_PIPE_LZC_EN)
module zero_flag_level #(
  parameter int FANIN = 4,
  parameter int OUT_W = 1,
  parameter int TAGW  = 5,
  parameter int LZW   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     valid_i,
  input  logic                     msb_i,
  input  logic [TAGW-1:0]          tag_i,
  input  logic [OUT_W*FANIN-1:0]   or_i,
`ifdef ZERO_FLAG_PIPE_LZC_EN
  input  logic [OUT_W*FANIN*LZW-1:0] lzc_i,
  output logic [OUT_W*LZW-1:0]     lzc_o,
`endif
  output logic                     valid_o,
  output logic                     msb_o,
  output logic [TAGW-1:0]          tag_o,
  output logic [OUT_W-1:0]         or_o
);

  logic             valid_d, valid_q;
  logic             msb_d, msb_q;
  logic [TAGW-1:0]  tag_d, tag_q;
  logic [OUT_W-1:0] or_d, or_q;

  always_comb begin
    valid_d = valid_q;
    msb_d   = msb_q;
    tag_d   = tag_q;
    or_d    = or_q;
    if (flush) valid_d = 1'b0;
    else if (!stall) valid_d = valid_i;
    if (!stall) begin
      msb_d = msb_i;
      for (int j = 0; j < OUT_W; j++) or_d[j] = |or_i[j*FANIN +: FANIN];
    end
    // The tag only follows live operands so the output tag keeps the last
    // delivered value while nothing valid is presented.
    if (!stall && !flush && valid_i) tag_d = tag_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      msb_q   <= 1'b0;
      tag_q   <= '0;
      or_q    <= '0;
    end else begin
      valid_q <= valid_d;
      msb_q   <= msb_d;
      tag_q   <= tag_d;
      or_q    <= or_d;
    end
  end

  assign valid_o = valid_q;
  assign msb_o   = msb_q;
  assign tag_o   = tag_q;
  assign or_o    = or_q;

`ifdef ZERO_FLAG_PIPE_LZC_EN
  logic [OUT_W*LZW-1:0] lzc_d, lzc_q;
  logic [LZW-1:0]       acc;
  logic                 hit;

  // Walk children from the most significant one: all-zero children add their
  // full count, the first non-zero child adds its own count and stops the walk.
  always_comb begin
    lzc_d = lzc_q;
    acc   = '0;
    hit   = 1'b0;
    if (!stall) begin
      for (int j = 0; j < OUT_W; j++) begin
        acc = '0;
        hit = 1'b0;
        for (int c = FANIN - 1; c >= 0; c--) begin
          if (!hit) acc = acc + lzc_i[(j*FANIN + c)*LZW +: LZW];
          if (or_i[j*FANIN + c]) hit = 1'b1;
        end
        lzc_d[j*LZW +: LZW] = acc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lzc_q <= '0;
    else       lzc_q <= lzc_d;
  end

  assign lzc_o = lzc_q;
`endif

endmodule

// File: rtl/zero_flag_pipe.sv
// zero_flag_pipe
// Pipelined zero/negative flag generator. The operand is zero-padded to
// FANIN**LEVELS bits and reduced through LEVELS registered OR levels; valid,
// MSB and tag travel with it. Latency is LEVELS edges including the accepting
// edge. Optional macro ZERO_FLAG_PIPE_LZC_EN adds out_lzc (leading-zero count).
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   in_valid/in_data/in_tag - operand presented this cycle
//   stall            - hold every pipeline register
//   flush            - kill every in-flight operand (priority over stall)
//   out_valid        - result valid
//   out_zero/out_neg - operand was zero / operand MSB, gated by out_valid
//   out_tag          - tag of the last delivered operand
//   out_lzc          - leading zeros from the MSB, gated (LZC build only)
// Valid/ready: there is no backpressure output; an operand is taken on every
// edge with stall=0 and flush=0, and upstream holds its inputs while stalled.
module zero_flag_pipe
  import zero_flag_pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int FANIN = 4,
  parameter int TAGW  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [TAGW-1:0]            in_tag,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       out_valid,
  output logic                       out_zero,
  output logic                       out_neg,
`ifdef ZERO_FLAG_PIPE_LZC_EN
  output logic [$clog2(WIDTH+1)-1:0] out_lzc,
`endif
  output logic [TAGW-1:0]            out_tag
);

  localparam int LEVELS  = calc_levels(WIDTH, FANIN);
  localparam int PADW    = padded_width(WIDTH, FANIN);
  localparam int TOTW    = level_offset(WIDTH, FANIN, LEVELS + 1);
  localparam int TOP_OFF = level_offset(WIDTH, FANIN, LEVELS);
  localparam int LZW     = $clog2(PADW + 1);
  localparam int OLZW    = $clog2(WIDTH + 1);

  // Whole OR tree flattened: level 0 is the padded operand, level LEVELS is 1 bit.
  logic [TOTW-1:0] or_all;
  logic            valid_c [0:LEVELS];
  logic            msb_c   [0:LEVELS];
  logic [TAGW-1:0] tag_c   [0:LEVELS];

  assign or_all[PADW-1:0] = PADW'(in_data);
  assign valid_c[0]       = in_valid;
  assign msb_c[0]         = in_data[WIDTH-1];
  assign tag_c[0]         = in_tag;

`ifdef ZERO_FLAG_PIPE_LZC_EN
  logic [TOTW*LZW-1:0] lzc_all;
  for (genvar i = 0; i < PADW; i++) begin : g_lzc_leaf
    assign lzc_all[i*LZW +: LZW] = {{(LZW-1){1'b0}}, ~or_all[i]};
  end
`endif

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int IN_OFF  = level_offset(WIDTH, FANIN, k - 1);
    localparam int OUT_OFF = level_offset(WIDTH, FANIN, k);
    localparam int OUT_W   = level_width(WIDTH, FANIN, k);

    zero_flag_level #(
      .FANIN (FANIN),
      .OUT_W (OUT_W),
      .TAGW  (TAGW),
      .LZW   (LZW)
    ) u_level (
      .clk     (clk),
      .reset   (reset),
      .stall   (stall),
      .flush   (flush),
      .valid_i (valid_c[k-1]),
      .msb_i   (msb_c[k-1]),
      .tag_i   (tag_c[k-1]),
      .or_i    (or_all[IN_OFF +: OUT_W*FANIN]),
`ifdef ZERO_FLAG_PIPE_LZC_EN
      .lzc_i   (lzc_all[IN_OFF*LZW +: OUT_W*FANIN*LZW]),
      .lzc_o   (lzc_all[OUT_OFF*LZW +: OUT_W*LZW]),
`endif
      .valid_o (valid_c[k]),
      .msb_o   (msb_c[k]),
      .tag_o   (tag_c[k]),
      .or_o    (or_all[OUT_OFF +: OUT_W])
    );
  end

  assign out_valid = valid_c[LEVELS];
  assign out_zero  = valid_c[LEVELS] & ~or_all[TOP_OFF];
  assign out_neg   = valid_c[LEVELS] & msb_c[LEVELS];
  assign out_tag   = tag_c[LEVELS];

`ifdef ZERO_FLAG_PIPE_LZC_EN
  // The tree counts the constant pad zeros above the real MSB; remove them.
  assign out_lzc = valid_c[LEVELS]
                 ? OLZW'(lzc_all[TOP_OFF*LZW +: LZW] - LZW'(PADW - WIDTH))
                 : '0;
`endif

endmodule

// File: doc/zero_flag_pipe.md
Name: zero_flag_pipe

Overview:
Parametrised, pipelined zero/negative flag generator for the ALU result and flag-setting path of the pipelined ARM core. It is the registered successor to the single-cycle zero checker. It reduces a WIDTH-bit operand through a FANIN-ary OR tree with one register per tree level, and tracks valid/tag alongside. It supports stall and flush from the hazard unit, so the long reduction never sits on a single-cycle critical path.

Parameters:
WIDTH, 64, operand width; any value >= 2 (non-power-of-FANIN widths are zero-padded at the top).
FANIN, 4, inputs per OR node; power of two, 2..8.
TAGW, 5, width of the sideband tag (destination register id) carried with each operand.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  operand on in_data is valid this cycle.
in_data  input  WIDTH  operand to test.
in_tag  input  TAGW  sideband tag, returned unchanged with result.
stall  input  1  hold every pipeline register this cycle.
flush  input  1  kill every in-flight operand.
out_valid  output  1  result valid.
out_zero  output  1  1 when the operand was all zeros; 0 whenever out_valid=0.
out_neg  output  1  operand MSB (in_data[WIDTH-1]); 0 whenever out_valid=0.
out_tag  output  TAGW  tag of the operand; holds its last value when out_valid=0.

Behaviour:
- LEVELS = ceil(log_FANIN(WIDTH)), minimum 1. Latency = LEVELS cycles from the accepting edge to out_valid (WIDTH=64, FANIN=4 gives 3).
- Level k registers the OR of each FANIN-group from level k-1. Pad bits are constant 0. After the last level, out_zero = ~or_result & out_valid.
- MSB and tag ride in parallel registers with identical latency. One valid bit per level.
- Acceptance: an operand is accepted on an edge where stall=0 and flush=0. Its valid bit enters level 1 equal to in_valid. Data registers load every non-stalled edge, regardless of valid.
- Stall: with stall=1 and flush=0, all valid, data, MSB and tag registers hold. Inputs are ignored and upstream must hold them. Outputs stay constant for the whole stall.
- Flush: on an edge with flush=1, all valid bits clear, including the operand presented that cycle. Flush has priority over stall. Data registers may update or hold; this is not observable because outputs are gated.
- Throughput: one operand per non-stalled cycle. Back-to-back operands emerge on consecutive cycles in order.
- Reset: while reset=1, all valid bits, data regs, MSB and tag regs are 0. Outputs are all 0. Reset asserted mid-operation discards everything in flight. The first operand after reset deassertion is accepted on the first clean edge.
- No state machine beyond the valid shift chain. No combinational path from inputs to outputs.

Optional Feature:
Macro ZERO_FLAG_PIPE_LZC_EN.
- Defined: adds output out_lzc, width $clog2(WIDTH+1), giving the leading-zero count of the operand counted from the MSB (WIDTH when all zero). It is computed per tree level alongside the OR reduction, with the same latency, stall, flush and gating; it reads 0 when out_valid=0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package zero_flag_pipe_pkg: a constant function computing LEVELS from WIDTH and FANIN, a function computing padded width, and the per-level width helper.
- One natural sub-module, zero_flag_level: a single registered FANIN-ary OR level (plus LZC merge when enabled) with stall/flush-aware enables. It is instantiated LEVELS times in a generate loop.

Test Plan (WIDTH=64, FANIN=4, TAGW=5, latency 3):
- Reset, then in_valid=1, in_data=0, in_tag=7 -> 3 cycles later out_valid=1, out_zero=1, out_neg=0, out_tag=7; with LZC enabled, out_lzc=64.
- Back-to-back operands 0x0, 0x1, 0x8000_0000_0000_0000, 0x0 -> out_zero 1,0,0,1 and out_neg 0,0,1,0 on four consecutive cycles; with LZC enabled, out_lzc 64,63,0,64.
- Operand 0x0 accepted, stall=1 for 4 cycles after 1 cycle -> result appears 7 cycles after acceptance; outputs frozen during stall.
- Two operands in flight, flush=1 for one cycle (also with stall=1) -> neither emerges, out_valid stays 0, out_zero 0; next operand 0x10 yields out_zero=0 after 3 cycles.
- Reset asserted asynchronously mid-flight with operand 0x0 -> out_valid drops immediately, nothing emerges after release.
- Parameter sweep WIDTH=5 FANIN=2 (LEVELS=3) and WIDTH=33 FANIN=8 (LEVELS=2): all-zero gives out_zero=1; single bit set at each position gives out_zero=0.
